uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

- Stand-alone, run-time configurable UART receiver.
- Decodes the serial line produced by the team's configurable transmitter:
  - 5–8 data bits, LSB first
  - optional even/odd parity
  - 1 or 2 stop bits
- Reports each received frame on a parallel output with a one-cycle done pulse and an error flag.
- Sits on the receive side of the UART subsystem, fed by the pad or a loopback of the transmitter's serial output.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  system clock
- rst  input  1  reset
- rx_start  input  1  receiver enable; level-sensitive
- rx  input  1  serial line; idle high
- baud  input  17  baud rate in bit/s; sampled only in IDLE
- length  input  4  data bits per frame; 5..8 valid, anything else is treated as 8
- parity_en  input  1  parity bit present
- parity_type  input  1  1 = odd parity, 0 = even
- stop2  input  1  1 = two stop bits
- rx_done  output  1  one-cycle pulse, frame complete
- rx_err  output  1  valid with rx_done: parity or framing error
- rx_out  output  8  received data, zero-extended above length

## Operation
- Bit period: cpb = CLK_FREQ / baud, computed and registered on leaving IDLE. Config inputs are also captured then; changes mid-frame are ignored.
- Half period: hpb = cpb >> 1.
- States: IDLE → START → DATA → PARITY → STOP → DONE → IDLE.
- IDLE:
  - Leaves only when rx_start = 1, baud ≠ 0 and a falling edge is seen on rx (previous sample 1, current 0).
  - Clears the bit counter, the shift register and the error accumulator.
- START:
  - Waits hpb cycles, then samples rx.
  - If 1: false start, return to IDLE with no done pulse.
  - If 0: go to DATA.
- DATA:
  - Samples every cpb cycles; each bit is shifted LSB first.
  - After `length` bits, goes to PARITY if parity_en, else STOP.
- PARITY:
  - Samples one bit.
  - Error if (XOR of data bits ^ parity bit) ≠ parity_type.
- STOP:
  - Samples 1 or 2 (stop2) bits at cpb spacing.
  - Any stop sample = 0 sets a framing error.
- DONE, one cycle:
  - rx_done = 1; rx_err = accumulated error.
  - rx_out is loaded with the shifted data, right-aligned, upper bits 0.
- rx_out holds its value until the next DONE, including after an errored frame.
- rx_start deasserted mid-frame: the current frame completes; no new frame starts.
- A falling edge on rx during DONE is not lost. A frame starting on the cycle after the last stop sample is detected, because edge detection continues in DONE.
- Reset at any time: returns to IDLE on the next clk edge and discards the partial frame. Reset values: rx_done = 0, rx_err = 0, rx_out = 8'h00.

## Timing
- Cycle 0 is the clk edge at which the falling edge is detected.
- Start bit sampled at cycle hpb.
- Data bit k (k = 0..length-1) sampled at hpb + (k+1)·cpb.
- Each later bit (parity, stops) adds cpb.
- rx_done is asserted in the cycle after the final stop sample.
- Example at 50 MHz, 57600 baud: cpb = 868, hpb = 434. An 8N1 frame samples its stop bit at cycle 8246, and rx_done is high in cycle 8247.
- With UART_RX_MAJORITY_EN, every sample point moves +1 cycle.
- rx_err is valid only while rx_done = 1; it is 0 otherwise.

## Configuration
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit decision is the 2-of-3 majority of rx sampled at sample point −1, sample point, and sample point +1.
  - The decision is therefore taken one cycle later; all sample points shift +1 cycle.
  - Filters single-cycle glitches.
- Undefined: a single sample at the sample point; no extra latency.

## Structure
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE)
  - parity constants PAR_EVEN = 0, PAR_ODD = 1
  - function clks_per_bit(clk_freq, baud)
  - constant MAX_DATA_BITS = 8
- One sub-module, uart_rx_bittimer:
  - a counter loaded with hpb or cpb
  - emits a one-cycle sample tick
  - restarted by the FSM

## Test plan
- rx_start = 1, 57600 baud, length 8, parity_en 1, parity_type 1 (odd), stop2 0, serial 8'hAF with parity bit 1 → rx_out = 8'hAF, rx_err = 0, rx_done high at cycle 9115.
- Same frame with parity bit flipped to 0 → rx_done with rx_err = 1, rx_out = 8'hAF.
- length 5, no parity, stop2 1, serial 5'h15, second stop bit driven 0 → rx_out = 8'h15, rx_err = 1 (framing error).
- 400-cycle low pulse on rx (shorter than hpb = 434) → no rx_done; FSM back in IDLE; the next valid frame 8'h3C is received correctly.
- Two back-to-back 8N1 frames 8'h01 then 8'hFE with no idle gap → two rx_done pulses 8680 cycles apart, both with rx_err = 0.
- rst asserted for one cycle in the middle of DATA → rx_out = 0, rx_done = 0, IDLE; the following frame 8'h5A is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM states, parity
// constants and bit-timing / parity / majority helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int MAX_DATA_BITS = 8;
    localparam int CNT_W         = 32;

    function automatic logic [CNT_W-1:0] clks_per_bit(input logic [31:0] clk_freq,
                                                      input logic [16:0] baud);
        logic [CNT_W-1:0] cpb_v;
        if (baud == 17'd0) begin
            cpb_v = '0;
        end else begin
            cpb_v = clk_freq / {15'd0, baud};
        end
        return cpb_v;
    endfunction

    // Unused upper data bits are zero, so they do not disturb the XOR.
    function automatic logic parity_err(input logic [7:0] data,
                                        input logic       par_bit,
                                        input logic       par_type);
        return (^data ^ par_bit) != (par_type == PAR_ODD);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_bittimer.sv
// Bit timer: loaded with the half period on restart, then reloads with the
// full period, giving a one-cycle registered tick at each sample point.
module uart_rx_bittimer
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             run,
    input  logic [CNT_W-1:0] hpb,
    input  logic [CNT_W-1:0] cpb,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tick_r;

    function automatic logic [CNT_W-1:0] minus1(input logic [CNT_W-1:0] x);
        logic [CNT_W-1:0] r;
        if (x == '0) begin
            r = '0;
        end else begin
            r = x - CNT_W'(1);
        end
        return r;
    endfunction

    // Next count value: restart, reload on expiry, or count down.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (restart) begin
            cnt_nxt_s = minus1(hpb);
        end else if (run) begin
            if (cnt_r == '0) begin
                cnt_nxt_s = minus1(cpb);
            end else begin
                cnt_nxt_s = cnt_r - CNT_W'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Counter and registered tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (restart | run) && (cnt_nxt_s == '0);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_rx_cfg.sv
// Run-time configurable UART receiver (5-8 data bits, optional parity, 1/2 stops).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions (+1 cycle latency).
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_start,
    input  logic        rx,
    input  logic [16:0] baud,
    input  logic [3:0]  length,
    input  logic        parity_en,
    input  logic        parity_type,
    input  logic        stop2,
    output logic        rx_done,
    output logic        rx_err,
    output logic [7:0]  rx_out
);

    uart_state_e      state_r;
    logic             rx_prev_r;
    logic [CNT_W-1:0] cpb_r;
    logic [CNT_W-1:0] cpb_in_s;
    logic [CNT_W-1:0] hpb_in_s;
    logic [3:0]       len_r;
    logic [3:0]       len_in_s;
    logic [3:0]       bit_cnt_r;
    logic             par_en_r;
    logic             ptype_r;
    logic             stop2_r;
    logic             stop_idx_r;
    logic             err_r;
    logic [7:0]       shift_r;
    logic [7:0]       aligned_s;
    logic             start_s;
    logic             run_s;
    logic             tick_s;
    logic             bit_tick_s;
    logic             bit_val_s;

    // Frame configuration seen on the line right now, and start detection.
    always_comb begin
        cpb_in_s  = clks_per_bit(32'(CLK_FREQ), baud);
        hpb_in_s  = cpb_in_s >> 1;
        len_in_s  = ((length >= 4'd5) && (length <= 4'd8)) ? length : 4'd8;
        start_s   = ((state_r == IDLE) || (state_r == DONE)) && rx_start &&
                    (baud != 17'd0) && rx_prev_r && !rx;
        run_s     = (state_r == START) || (state_r == DATA) ||
                    (state_r == PARITY) || (state_r == STOP);
        aligned_s = shift_r >> (4'(MAX_DATA_BITS) - len_r);
    end

    // Previous line sample for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_r <= 1'b0;
        end else begin
            rx_prev_r <= rx;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_prev2_r;
    logic tick_d_r;

    // Sample history and delayed tick so the decision sees sp-1, sp, sp+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev2_r <= 1'b0;
            tick_d_r   <= 1'b0;
        end else begin
            rx_prev2_r <= rx_prev_r;
            tick_d_r   <= tick_s;
        end
    end

    // Majority bit decision one cycle after the sample point.
    always_comb begin
        bit_tick_s = tick_d_r;
        bit_val_s  = maj3(rx_prev2_r, rx_prev_r, rx);
    end
`else
    // Single-sample bit decision at the sample point.
    always_comb begin
        bit_tick_s = tick_s;
        bit_val_s  = rx;
    end
`endif

    uart_rx_bittimer u_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (start_s),
        .run     (run_s),
        .hpb     (hpb_in_s),
        .cpb     (cpb_r),
        .tick    (tick_s)
    );

    // Receive FSM with registered outputs; a start in DONE overrides the return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cpb_r      <= '0;
            len_r      <= 4'd8;
            par_en_r   <= 1'b0;
            ptype_r    <= 1'b0;
            stop2_r    <= 1'b0;
            bit_cnt_r  <= 4'd0;
            stop_idx_r <= 1'b0;
            shift_r    <= 8'h00;
            err_r      <= 1'b0;
            rx_done    <= 1'b0;
            rx_err     <= 1'b0;
            rx_out     <= 8'h00;
        end else begin
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                START: begin
                    if (bit_tick_s) begin
                        state_r <= bit_val_s ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bit_tick_s) begin
                        shift_r <= {bit_val_s, shift_r[7:1]};
                        if (bit_cnt_r == (len_r - 4'd1)) begin
                            state_r <= par_en_r ? PARITY : STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick_s) begin
                        if (parity_err(shift_r, bit_val_s, ptype_r)) begin
                            err_r <= 1'b1;
                        end
                        state_r <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick_s) begin
                        if (!bit_val_s) begin
                            err_r <= 1'b1;
                        end
                        if (stop2_r && !stop_idx_r) begin
                            stop_idx_r <= 1'b1;
                        end else begin
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    rx_done <= 1'b1;
                    rx_err  <= err_r;
                    rx_out  <= aligned_s;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
            if (start_s) begin
                state_r    <= START;
                cpb_r      <= cpb_in_s;
                len_r      <= len_in_s;
                par_en_r   <= parity_en;
                ptype_r    <= parity_type;
                stop2_r    <= stop2;
                bit_cnt_r  <= 4'd0;
                stop_idx_r <= 1'b0;
                shift_r    <= 8'h00;
                err_r      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: vector table, hand-written corner
// sequences and randomized frames checked against a behavioural model.
module tb_uart_rx_cfg;

    localparam int CLK_FREQ = 50_000_000;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_start;
    logic        rx;
    logic [16:0] baud;
    logic [3:0]  length;
    logic        parity_en;
    logic        parity_type;
    logic        stop2;
    logic        rx_done;
    logic        rx_err;
    logic [7:0]  rx_out;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int err_leak = 0;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       err;
    } done_t;
    done_t dq[$];

    typedef struct {
        int         baud;
        logic [3:0] length;
        logic       pe;
        logic       pt;
        logic       s2;
        logic [7:0] data;
        logic       flip;
        logic [1:0] stop_bad;
        logic [7:0] exp_out;
        logic       exp_err;
        int         exp_lat;
    } vec_t;
    vec_t vt[6];

    uart_rx_cfg #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_start    (rx_start),
        .rx          (rx),
        .baud        (baud),
        .length      (length),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .rx_out      (rx_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done) dq.push_back('{cyc, rx_out, rx_err});
        else if (rx_err) err_leak++;
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int eff_len(input logic [3:0] l);
        return (l >= 4'd5 && l <= 4'd8) ? int'(l) : 8;
    endfunction

    function automatic logic odd_ones(input logic [7:0] d, input int n);
        logic p = 1'b0;
        for (int i = 0; i < n; i++) p ^= d[i];
        return p;
    endfunction

    // Reference: what the receiver must report for a frame as transmitted.
    task automatic model(input int b, input logic [3:0] l, input logic pe, input logic pt,
                         input logic s2, input logic [7:0] d, input logic pb,
                         input logic [1:0] sv, output logic [7:0] o, output logic e,
                         output int lat);
        int n, c;
        logic [8:0] m;
        n = eff_len(l);
        c = CLK_FREQ / b;
        m = (9'd1 << n) - 9'd1;
        o = d & m[7:0];
        e = 1'b0;
        if (pe && ((($countones(o) + int'(pb)) % 2) != int'(pt))) e = 1'b1;
        if (!sv[0]) e = 1'b1;
        if (s2 && !sv[1]) e = 1'b1;
        lat = c / 2 + (n + int'(pe) + 1 + int'(s2)) * c + 1 + MAJ;
    endtask

    task automatic send_frame(input int b, input logic [3:0] l, input logic pe, input logic pt,
                              input logic s2, input logic [7:0] d, input logic pb,
                              input logic [1:0] sv, input logic en, input logic scr,
                              output int t0);
        int c, n;
        c = CLK_FREQ / b;
        n = eff_len(l);
        baud = 17'(b); length = l; parity_en = pe; parity_type = pt; stop2 = s2;
        rx_start = en;
        t0 = cyc + 1;
        line(1'b0, c);
        if (scr) begin
            baud = 17'($urandom); length = 4'($urandom); parity_en = 1'($urandom);
            parity_type = 1'($urandom); stop2 = 1'($urandom); rx_start = 1'($urandom);
        end
        for (int i = 0; i < n; i++) line(d[i], c);
        if (pe) line(pb, c);
        line(sv[0], c);
        if (s2) line(sv[1], c);
    endtask

    task automatic expect_frame(input string nm, input int t0, input logic [7:0] eo,
                                input logic ee, input int el);
        done_t r;
        check({nm, "_count"}, dq.size(), 1);
        if (dq.size() > 0) begin
            r = dq.pop_front();
            check({nm, "_data"}, int'(r.data), int'(eo));
            check({nm, "_err"}, int'(r.err), int'(ee));
            check({nm, "_latency"}, r.cyc - t0, el);
        end
        dq.delete();
    endtask

    initial begin
        int t0, t1, b;
        logic pbit, pe, pt, s2;
        logic [3:0] l;
        logic [1:0] sv;
        logic [7:0] d, eo;
        logic ee;
        int el;
        done_t r1, r2;

        vt[0] = '{57600,  4'd8,  1'b1, 1'b1, 1'b0, 8'hAF, 1'b0, 2'b00, 8'hAF, 1'b0, 9115};
        vt[1] = '{57600,  4'd8,  1'b1, 1'b1, 1'b0, 8'hAF, 1'b1, 2'b00, 8'hAF, 1'b1, 9115};
        vt[2] = '{125000, 4'd5,  1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 2'b10, 8'h15, 1'b1, 3001};
        vt[3] = '{125000, 4'd12, 1'b1, 1'b0, 1'b0, 8'h81, 1'b0, 2'b00, 8'h81, 1'b0, 4201};
        vt[4] = '{125000, 4'd6,  1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 2'b00, 8'h3F, 1'b0, 3801};
        vt[5] = '{125000, 4'd5,  1'b0, 1'b0, 1'b0, 8'h0A, 1'b0, 2'b01, 8'h0A, 1'b1, 2601};

        rst = 1'b1; rx = 1'b1; rx_start = 1'b0; baud = 17'd57600; length = 4'd8;
        parity_en = 1'b0; parity_type = 1'b0; stop2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_done", int'(rx_done), 0);
        check("reset_err", int'(rx_err), 0);
        check("reset_out", int'(rx_out), 0);
        line(1'b1, 5);

        for (int i = 0; i < 6; i++) begin
            pbit = odd_ones(vt[i].data, eff_len(vt[i].length)) ^ vt[i].pt ^ vt[i].flip;
            send_frame(vt[i].baud, vt[i].length, vt[i].pe, vt[i].pt, vt[i].s2, vt[i].data,
                       pbit, ~vt[i].stop_bad, 1'b1, 1'b0, t0);
            line(1'b1, 20);
            expect_frame($sformatf("vec%0d", i), t0, vt[i].exp_out, vt[i].exp_err,
                         vt[i].exp_lat + MAJ);
        end
        check("hold_after_err", int'(rx_out), 8'h0A);

        // Start-bit glitch shorter than half a bit, then a good frame.
        baud = 17'd57600; length = 4'd8; parity_en = 1'b0; stop2 = 1'b0; rx_start = 1'b1;
        line(1'b0, 400);
        line(1'b1, 1000);
        check("glitch_nodone", dq.size(), 0);
        send_frame(57600, 4'd8, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 2'b11, 1'b1, 1'b0, t0);
        line(1'b1, 20);
        expect_frame("after_glitch", t0, 8'h3C, 1'b0, 8247 + MAJ);

        // Back-to-back frames with no idle gap.
        send_frame(57600, 4'd8, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 2'b11, 1'b1, 1'b0, t0);
        send_frame(57600, 4'd8, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 2'b11, 1'b1, 1'b0, t1);
        line(1'b1, 20);
        check("b2b_count", dq.size(), 2);
        if (dq.size() == 2) begin
            r1 = dq.pop_front();
            r2 = dq.pop_front();
            check("b2b_data0", int'(r1.data), 8'h01);
            check("b2b_data1", int'(r2.data), 8'hFE);
            check("b2b_err0", int'(r1.err), 0);
            check("b2b_err1", int'(r2.err), 0);
            check("b2b_latency0", r1.cyc - t0, 8247 + MAJ);
            check("b2b_spacing", r2.cyc - r1.cyc, 8680);
        end
        dq.delete();

        // Reset in the middle of DATA discards the frame.
        baud = 17'd125000; length = 4'd8; parity_en = 1'b0; stop2 = 1'b0; rx_start = 1'b1;
        line(1'b0, 400);
        line(1'b0, 400);
        line(1'b1, 400);
        line(1'b0, 150);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_out", int'(rx_out), 0);
        check("midrst_done", int'(rx_done), 0);
        check("midrst_err", int'(rx_err), 0);
        line(1'b1, 100);
        send_frame(125000, 4'd8, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 2'b11, 1'b1, 1'b0, t0);
        line(1'b1, 20);
        expect_frame("after_rst", t0, 8'h5A, 1'b0, 3801 + MAJ);

        // Receiver disabled: frame on the line is ignored.
        send_frame(125000, 4'd5, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 2'b11, 1'b0, 1'b0, t0);
        line(1'b1, 20);
        check("disabled_nodone", dq.size(), 0);
        dq.delete();

        // Random frames; config inputs are scrambled once the frame is under way.
        for (int k = 0; k < 3; k++) begin
            b  = $urandom_range(131071, 100000);
            l  = 4'($urandom_range(15, 0));
            pe = 1'($urandom); pt = 1'($urandom); s2 = 1'($urandom);
            d  = 8'($urandom);
            pbit = odd_ones(d, eff_len(l)) ^ pt ^ ($urandom_range(3, 0) == 0);
            sv = {1'($urandom_range(4, 0) != 0), 1'($urandom_range(4, 0) != 0)};
            model(b, l, pe, pt, s2, d, pbit, sv, eo, ee, el);
            send_frame(b, l, pe, pt, s2, d, pbit, sv, 1'b1, 1'b1, t0);
            line(1'b1, 20);
            expect_frame($sformatf("rnd%0d", k), t0, eo, ee, el);
        end

        check("err_outside_done", err_leak, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
